// File: rtl/game_pkg.sv
// Shared game-flow encodings and constants used by the renderer, this controller and the display.
// Definitions only: no logic, no latency, no flow control.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_CRASHED  = 2'd2,
        ST_GAMEOVER = 2'd3
    } game_state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // 12-bit RGB colours shared by the renderer and the overlay
    localparam logic [11:0] COL_ROAD  = 12'h444;
    localparam logic [11:0] COL_CAR   = 12'hF00;
    localparam logic [11:0] COL_FLASH = 12'hFFF;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer with clear priority over increment, saturating at 9999.
// Count updates on the clock edge after clr/inc; no backpressure.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        carry;

    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != BCD_MAX)) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow FSM: start/crash sequencing, frame-divided BCD score and high score.
// All outputs registered, one cycle after the causing input; no backpressure.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_DIV    = 4,
    parameter int CRASH_FRAMES = 120,
    parameter int GRACE_FRAMES = 2,
    parameter int FLASH_BIT    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        dead_flag,
    output logic        restart,
    output logic        playing,
    output logic        crash_flash,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    localparam int CW = ($clog2(CRASH_FRAMES) > 7) ? $clog2(CRASH_FRAMES) : 7;
    localparam int GW = ($clog2(GRACE_FRAMES + 1) > 2) ? $clog2(GRACE_FRAMES + 1) : 2;
    localparam logic [3:0]    DIV_LAST = 4'(SCORE_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CRASH_FRAMES - 1);

    game_state_t   state_q, state_d;
    logic          btn_q;
    logic [3:0]    div_q, div_d;
    logic [GW-1:0] grace_q, grace_d;
    logic [CW-1:0] crash_cnt_q, crash_cnt_d;
    logic [15:0]   high_q, high_d;
    logic          restart_q, restart_d;
    logic          playing_q, playing_d;
    logic          flash_q, flash_d;
    logic          score_clr, score_inc;
    logic          start_press;
    logic          crash_hit;

    assign start_press = start_btn & ~btn_q;
    // The renderer emits a crash pulse right after its own reset; grace hides it.
    assign crash_hit   = (state_q == ST_PLAYING) && (grace_q == '0) && dead_flag;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        grace_d     = grace_q;
        crash_cnt_d = crash_cnt_q;
        high_d      = high_q;
        restart_d   = 1'b0;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_press) begin
                    state_d   = ST_PLAYING;
                    restart_d = 1'b1;
                    score_clr = 1'b1;
                    div_d     = '0;
                    grace_d   = GW'(GRACE_FRAMES);
                end
            end
            ST_PLAYING: begin
                if (crash_hit) begin
                    state_d     = ST_CRASHED;
                    crash_cnt_d = '0;
                    if (score > high_q) begin
                        high_d = score;
                    end
                end else if (frame_tick) begin
                    if (grace_q != '0) begin
                        grace_d = grace_q - 1'b1;
                    end
                    if (div_q == DIV_LAST) begin
                        div_d     = '0;
                        score_inc = 1'b1;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            end
            ST_CRASHED: begin
                if (frame_tick) begin
                    if (crash_cnt_q == CNT_LAST) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        crash_cnt_d = crash_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        playing_d = (state_d == ST_PLAYING);
        flash_d   = (state_d == ST_CRASHED) && crash_cnt_d[FLASH_BIT];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            btn_q       <= 1'b0;
            div_q       <= '0;
            grace_q     <= '0;
            crash_cnt_q <= '0;
            high_q      <= '0;
            restart_q   <= 1'b0;
            playing_q   <= 1'b0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= start_btn;
            div_q       <= div_d;
            grace_q     <= grace_d;
            crash_cnt_q <= crash_cnt_d;
            high_q      <= high_d;
            restart_q   <= restart_d;
            playing_q   <= playing_d;
            flash_q     <= flash_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score)
    );

    assign state       = state_q;
    assign restart     = restart_q;
    assign playing     = playing_q;
    assign crash_flash = flash_q;
    assign high_score  = high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed scoreboard bench for game_state_ctrl: driver queues expectations, negedge monitor checks.
// Restart pulses are matched against the cycle number predicted when the press is driven.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        start_btn;
    logic        dead_flag;
    logic        restart;
    logic        playing;
    logic        crash_flash;
    logic [1:0]  state;
    logic [15:0] score;
    logic [15:0] high_score;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hs;
        logic        pl;
        logic        fl;
        logic        rs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    rst_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    logic  done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    game_state_ctrl #(
        .SCORE_DIV    (4),
        .CRASH_FRAMES (120),
        .GRACE_FRAMES (2),
        .FLASH_BIT    (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .dead_flag   (dead_flag),
        .restart     (restart),
        .playing     (playing),
        .crash_flash (crash_flash),
        .state       (state),
        .score       (score),
        .high_score  (high_score)
    );

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] st, input logic [15:0] sc,
                              input logic [15:0] hs, input logic pl, input logic fl, input logic rs);
        exp_t e;
        e.st = st; e.sc = sc; e.hs = hs; e.pl = pl; e.fl = fl; e.rs = rs;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Press start; the transition edge is the next one, so restart shows at cyc+1.
    task automatic press_start(input string nm, input logic [15:0] hs);
        start_btn = 1'b1;
        rst_q.push_back(cyc + 1);
        step();
        expect_out(nm, 2'd1, 16'h0000, hs, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic crash_pulse();
        dead_flag = 1'b1;
        step();
        dead_flag = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        dead_flag  = 1'b0;
        steps(2);
        expect_out("reset", 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Game 1: start, grace masking, held button, score to 0x0017
        press_start("start1", 16'h0000);
        step();
        expect_out("restart_one_cycle", 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        crash_pulse();
        expect_out("grace_masks_dead", 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        steps(1000);
        expect_out("held_btn", 2'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        start_btn = 1'b0;
        step();
        ticks(40);
        expect_out("score_40_ticks", 2'd1, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(28);
        expect_out("score_17", 2'd1, 16'h0017, 16'h0000, 1'b1, 1'b0, 1'b0);
        crash_pulse();
        expect_out("crash1", 2'd2, 16'h0017, 16'h0017, 1'b0, 1'b0, 1'b0);
        ticks(120);
        expect_out("gameover1", 2'd3, 16'h0017, 16'h0017, 1'b0, 1'b0, 1'b0);

        // Game 2: new high score, flash timing, ignored inputs in CRASHED
        press_start("start2", 16'h0017);
        start_btn = 1'b0;
        step();
        ticks(92);
        expect_out("score_23", 2'd1, 16'h0023, 16'h0017, 1'b1, 1'b0, 1'b0);
        crash_pulse();
        expect_out("crash2_hs", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);
        ticks(7);
        expect_out("flash_7", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);
        ticks(1);
        expect_out("flash_8", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b1, 1'b0);
        ticks(8);
        expect_out("flash_16", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);
        start_btn = 1'b1;
        dead_flag = 1'b1;
        step();
        start_btn = 1'b0;
        dead_flag = 1'b0;
        step();
        expect_out("crashed_ignores", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);
        ticks(103);
        expect_out("crash_119", 2'd2, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);
        ticks(1);
        expect_out("gameover2", 2'd3, 16'h0023, 16'h0023, 1'b0, 1'b0, 1'b0);

        // Game 3: lower score keeps high score; tick+crash coincide at divider wrap
        press_start("start3", 16'h0023);
        start_btn = 1'b0;
        step();
        ticks(23);
        frame_tick = 1'b1;
        crash_pulse();
        frame_tick = 1'b0;
        expect_out("coincident_crash", 2'd2, 16'h0005, 16'h0023, 1'b0, 1'b0, 1'b0);
        ticks(10);
        rst_n = 1'b0;
        step();
        expect_out("reset_mid_crash", 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Game 4: BCD carries and saturation
        press_start("start4", 16'h0000);
        start_btn = 1'b0;
        step();
        ticks(396);
        expect_out("score_99", 2'd1, 16'h0099, 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(4);
        expect_out("carry_100", 2'd1, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(39596);
        expect_out("score_9999", 2'd1, 16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0);
        ticks(8);
        expect_out("saturate", 2'd1, 16'h9999, 16'h0000, 1'b1, 1'b0, 1'b0);
        crash_pulse();
        expect_out("crash4_hs", 2'd2, 16'h9999, 16'h9999, 1'b0, 1'b0, 1'b0);
        steps(3);
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
        end
    endtask

    initial begin
        exp_t  e;
        string nm;
        logic  restart_prev;
        restart_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (restart === 1'b1) begin
                total++;
                if (rst_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_restart cycle=%0d want=none", cyc);
                end else if (rst_q[0] != cyc) begin
                    bad++;
                    $display("FAIL restart_cycle got=%0d want=%0d", cyc, rst_q[0]);
                    void'(rst_q.pop_front());
                end else begin
                    void'(rst_q.pop_front());
                end
                total++;
                if (restart_prev) begin
                    bad++;
                    $display("FAIL restart_width got=2+ cycles want=1 cycle=%0d", cyc);
                end
            end
            restart_prev = (restart === 1'b1);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "state",       16'(state),       16'(e.st));
                cmp(nm, "score",       score,            e.sc);
                cmp(nm, "high_score",  high_score,       e.hs);
                cmp(nm, "playing",     16'(playing),     16'(e.pl));
                cmp(nm, "crash_flash", 16'(crash_flash), 16'(e.fl));
                cmp(nm, "restart",     16'(restart),     16'(e.rs));
            end
            if (done) begin
                total++;
                if (rst_q.size() != 0) begin
                    bad++;
                    $display("FAIL missing_restart got=%0d pending want=0", rst_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Game-flow controller directly downstream of the road/car renderer: consumes its one-cycle crash pulse and drives its restart input.
- Sequences IDLE -> PLAYING -> CRASHED -> GAMEOVER and keeps a 4-digit BCD score plus a high score.
- Score and high score feed the seven-segment driver.
- Runs in the pixel-clock domain and uses a frame tick from the VGA timing block.

Parameters:
- SCORE_DIV, 4, frames per score increment (1..15)
- CRASH_FRAMES, 120, frames held in CRASHED (crash flash period)
- GRACE_FRAMES, 2, frames after restart during which dead_flag is ignored
- FLASH_BIT, 3, bit of the crash frame counter that drives crash_flash

Ports:
- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse at start of each frame (hCount==0 && vCount==0)
- start_btn  in  1  debounced start button, level
- dead_flag  in  1  crash pulse from the renderer, one cycle wide
- restart  out  1  one-cycle pulse to the renderer's reset input
- playing  out  1  high only in PLAYING
- crash_flash  out  1  blink for the overlay; valid only in CRASHED, else 0
- state  out  2  0 IDLE, 1 PLAYING, 2 CRASHED, 3 GAMEOVER
- score  out  16  4 BCD digits, digit 3 in [15:12]
- high_score  out  16  4 BCD digits

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE; score=0; high_score=0; all counters=0; restart=0; crash_flash=0; btn_q=0.
- Start press = rising edge of start_btn (registered btn_q), so detection takes 1 cycle. A held button never re-triggers.
- IDLE -> PLAYING on a start press. Same cycle as the transition:
  - restart=1 for exactly 1 cycle;
  - score cleared;
  - frame divider cleared;
  - grace counter loaded with GRACE_FRAMES.
- PLAYING:
  - Grace counter decrements on each frame_tick until 0.
  - dead_flag is ignored while grace != 0. This masks the renderer's self-generated crash pulse that follows its own reset.
  - With grace==0, dead_flag=1 -> CRASHED next cycle; crash frame counter cleared.
  - Each frame_tick increments the frame divider. When the divider reaches SCORE_DIV-1 it wraps to 0 and score gets +1 in BCD.
  - BCD increment: a digit at 9 wraps to 0 and carries into the next digit. Score saturates at 9999 (no wrap to 0000).
  - frame_tick and dead_flag in the same cycle: the crash wins; no score increment that cycle.
- On entry to CRASHED (same edge as the transition): if score > high_score (unsigned compare of the 16-bit BCD values, which is valid for BCD), then high_score <= score.
- CRASHED:
  - Frame counter increments on frame_tick.
  - crash_flash = counter[FLASH_BIT].
  - Counter == CRASH_FRAMES-1 together with a frame_tick -> GAMEOVER.
  - start presses and dead_flag are ignored.
- GAMEOVER:
  - Score is held for display; crash_flash=0.
  - A start press -> PLAYING, with the same actions as from IDLE (restart pulse, score cleared, grace loaded).
- restart is registered: it is never high 2 consecutive cycles and never high outside a transition into PLAYING.
- playing is a registered decode of state, with no glitch.
- dead_flag outside PLAYING has no effect.
- rst_n asserted in any state, mid-frame: immediate return to the reset values at that edge. The high score is lost.
- Counter widths: frame divider 4 bits, crash counter 7 bits minimum (sized by clog2(CRASH_FRAMES)), grace counter 2 bits minimum.

Decomposition:
- Shared package game_pkg holds:
  - state encodings ST_IDLE, ST_PLAYING, ST_CRASHED, ST_GAMEOVER (2-bit);
  - BCD_MAX = 16'h9999.
- The renderer and the seven-segment/overlay logic import state and colours from game_pkg.
- One sub-module: bcd_counter4. It is a 4-digit BCD incrementer with:
  - clr and inc inputs;
  - saturation at 9999;
  - a sync active-low reset.
  - It is instantiated once for score. high_score is a plain register.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> state=0, score=0x0000, high_score=0x0000, restart=0, playing=0.
- start_btn rising edge in IDLE -> restart=1 for exactly 1 cycle, state=1 on that edge; start_btn held 1000 cycles -> no second restart.
- dead_flag pulse 2 cycles after restart (inside grace) -> stays PLAYING. After 40 frame_ticks with SCORE_DIV=4 -> score=0x0010.
- Preload score to 0x0099 and apply 4 ticks -> 0x0100. Preload 0x9999 and apply 8 ticks -> stays 0x9999.
- Crash pulse at score 0x0023 with high_score 0x0017 -> state=2 next cycle, high_score=0x0023. crash_flash toggles every 8 frames. After 120 frame_ticks -> state=3, score still 0x0023.
- A second game crashing at 0x0005 -> high_score stays 0x0023. Coincident frame_tick+dead_flag -> score unchanged. rst_n low mid-CRASHED -> IDLE next edge.
